cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between the two result producers: the RS ALU path and the LSB load/store path.
- Each producer gets a small in-order queue. A round-robin arbiter drains one entry per cycle onto a registered CDB.
- The CDB is consumed by the dispatcher, RS, LSB and RoB for wakeup and forwarding. Producers never broadcast directly.
- A mispredict flush clears all buffered results.

Parameters:
RoB_WIDTH, 4, width of RoB index carried on the bus
DATA_WIDTH, 32, width of result value
QUEUE_DEPTH, 2, entries per producer queue; power of two, >= 2
CNT_WIDTH, 2, width of per-queue occupancy counter; must hold 0..QUEUE_DEPTH

Ports:
Sys_clk  in  1  system clock, rising edge
Sys_rst_n  in  1  asynchronous active-low reset
Sys_rdy  in  1  global enable; when low all state freezes
RoB_flush  in  1  mispredict flush, synchronous, highest priority after reset
RSCDB_en  in  1  RS result valid
RSCDB_RoB_index  in  RoB_WIDTH  RoB entry of RS result
RSCDB_value  in  DATA_WIDTH  RS result value
CDBRS_ready  out  1  RS queue can accept this cycle
LSBCDB_en  in  1  LSB result valid
LSBCDB_RoB_index  in  RoB_WIDTH  RoB entry of LSB result
LSBCDB_value  in  DATA_WIDTH  LSB result value
CDBLSB_ready  out  1  LSB queue can accept this cycle
CDB_en  out  1  broadcast valid
CDB_RoB_index  out  RoB_WIDTH  broadcast RoB index
CDB_value  out  DATA_WIDTH  broadcast value
CDB_src  out  1  0 = RS, 1 = LSB

Behaviour:
- Reset (Sys_rst_n low, asynchronous):
  - CDB_en, CDB_RoB_index, CDB_value and CDB_src all go to 0.
  - Both queues are emptied (pointers and counters 0).
  - last_grant is set to LSB, so RS wins the first tie.
- Ready signals:
  - CDBx_ready = (count_x < QUEUE_DEPTH), derived from registered count only.
  - The decision is conservative: a dequeue in the same cycle does not free a slot.
  - A producer asserting en while ready is low is a protocol violation. The bench flags it; the RTL drops the request.
- Enqueue: at the rising edge with Sys_rdy=1 and no flush, x_en && CDBx_ready writes {index, value} at the tail and increments the tail pointer (mod QUEUE_DEPTH).
- Arbitration (every edge with Sys_rdy=1, no flush):
  - Candidate set is the queues with count > 0.
  - Both candidates: grant the source != last_grant.
  - One candidate: grant it.
  - None: CDB_en <= 0.
  - A grant registers the head into CDB_RoB_index, CDB_value and CDB_src, sets CDB_en <= 1, pops the head, and updates last_grant.
- Broadcast length: CDB_en is high for exactly one Sys_rdy-qualified cycle per result.
- Ordering: strictly FIFO within a source; no ordering between sources.
- Latency: a request sampled at edge t appears with CDB_en=1 after edge t+1 at the earliest. Worst case with both queues busy is bounded by 2*QUEUE_DEPTH cycles.
- Simultaneous enqueue and pop on the same queue: the counter is unchanged and the pointers both advance.
- Flush (RoB_flush=1 at an edge, Sys_rdy ignored):
  - Both queues are emptied and CDB_en <= 0.
  - Incoming requests in that cycle are discarded.
  - last_grant is kept.
- Sys_rdy=0: no enqueue, no pop, and no pointer, counter or last_grant update. All outputs hold their values, including CDB_en, since consumers are frozen too.
- Counter arithmetic is unsigned, CNT_WIDTH bits. Pointers are log2(QUEUE_DEPTH) bits and wrap naturally.

Optional Feature:
- Macro: CDB_BYPASS_EN.
- Defined:
  - A source whose queue is empty and whose en is high at edge t counts as a candidate for arbitration at edge t.
  - If it wins, its input goes straight to the CDB output registers, giving latency 1. It does not enqueue.
  - If it loses, it enqueues normally.
  - Per-source FIFO order is preserved because bypass only happens with an empty queue.
- Undefined: the minimum latency is 2 and every result passes through its queue.

Decomposition:
- Shared package cdb_pkg holds:
  - RoB_WIDTH and DATA_WIDTH defaults
  - CDB_SRC_RS = 1'b0 and CDB_SRC_LSB = 1'b1
  - the NON_DEP constant (1 << RoB_WIDTH), used by consumers
- Sub-module cdb_queue: a parameterized FIFO with {index, value} payload, exposing push, pop, flush, count, head and ready. It is instantiated twice; the arbiter logic stays in cdb_arbiter.

Test Plan:
- Single RS result idx 3, value 0x11 at edge 1 → CDB_en=1, idx 3, value 0x11, src 0 after edge 2; low after edge 3. With CDB_BYPASS_EN, the same appears after edge 1.
- RS idx 1 and LSB idx 2 in the same cycle after reset → RS broadcast first, LSB next cycle. The pattern then alternates when both queues are loaded.
- RS issues idx 4, 5, 6 back-to-back with LSB idle → CDBRS_ready drops when count=2. Broadcasts come out in order 4, 5, 6 with no gap once draining.
- Both queues full, RoB_flush pulsed for one cycle with RSCDB_en=1 → next cycle CDB_en=0, both ready=1, and no flushed index ever appears.
- Sys_rdy held low 3 cycles with CDB_en=1 idx 7 → outputs and counts unchanged. Draining resumes on the first edge with Sys_rdy=1.
- Assert Sys_rst_n low mid-broadcast, asynchronously between edges → CDB_en drops immediately and the queues are empty after release.

Source files
------------

// File: rtl/cdb_pkg.sv
// cdb_pkg: shared constants and types for the common data bus.
// Bus source codes, default widths and the "no dependency" tag.
package cdb_pkg;

  localparam int DEF_ROB_WIDTH  = 4;
  localparam int DEF_DATA_WIDTH = 32;

  localparam logic CDB_SRC_RS  = 1'b0;
  localparam logic CDB_SRC_LSB = 1'b1;

  // One past the largest RoB index: marks an operand as ready.
  localparam int NON_DEP = 1 << DEF_ROB_WIDTH;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_RS,
    GNT_LSB
  } gnt_e;

endpackage

// File: rtl/cdb_queue.sv
// cdb_queue: small in-order result queue holding {RoB index, value}.
// Ports: clk_i/rst_ni, en_i (global enable), flush_i, push_i + idx_i/val_i,
//   pop_i, head_idx_o/head_val_o, count_o, ready_o (count < DEPTH).
module cdb_queue #(
  parameter int IW    = 4,
  parameter int DW    = 32,
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [IW-1:0] idx_i,
  input  logic [DW-1:0] val_i,
  input  logic          pop_i,
  output logic [IW-1:0] head_idx_o,
  output logic [DW-1:0] head_val_o,
  output logic [CW-1:0] count_o,
  output logic          ready_o
);

  localparam int PW = $clog2(DEPTH);

  logic [IW-1:0] idx_mem_q [DEPTH];
  logic [DW-1:0] val_mem_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  // Ready comes from the registered count only, so a pop
  // in the same cycle never frees a slot for a push.
  assign ready_o = (cnt_q < CW'(DEPTH));
  assign do_push = en_i & ~flush_i & push_i & ready_o;
  assign do_pop  = en_i & ~flush_i & pop_i & (cnt_q != '0);

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push) tail_d = tail_q + 1'b1;
      if (do_pop)  head_d = head_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Payload storage needs no reset: count gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      idx_mem_q[tail_q] <= idx_i;
      val_mem_q[tail_q] <= val_i;
    end
  end

  assign head_idx_o = idx_mem_q[head_q];
  assign head_val_o = val_mem_q[head_q];
  assign count_o    = cnt_q;

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: queues RS and LSB results and round-robins them onto a
// registered common data bus, one broadcast per enabled cycle.
// Ports: Sys_clk, Sys_rst_n (async, low), Sys_rdy (freeze when low),
//   RoB_flush; RSCDB_*/LSBCDB_* producer requests with CDBRS_ready /
//   CDBLSB_ready; CDB_en, CDB_RoB_index, CDB_value, CDB_src (0=RS, 1=LSB).
// Option: define CDB_BYPASS_EN to let a request with an empty queue
//   win arbitration in the same cycle and skip its queue.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int RoB_WIDTH   = DEF_ROB_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int QUEUE_DEPTH = 2,
  parameter int CNT_WIDTH   = 2
) (
  input  logic                  Sys_clk,
  input  logic                  Sys_rst_n,
  input  logic                  Sys_rdy,
  input  logic                  RoB_flush,
  input  logic                  RSCDB_en,
  input  logic [RoB_WIDTH-1:0]  RSCDB_RoB_index,
  input  logic [DATA_WIDTH-1:0] RSCDB_value,
  output logic                  CDBRS_ready,
  input  logic                  LSBCDB_en,
  input  logic [RoB_WIDTH-1:0]  LSBCDB_RoB_index,
  input  logic [DATA_WIDTH-1:0] LSBCDB_value,
  output logic                  CDBLSB_ready,
  output logic                  CDB_en,
  output logic [RoB_WIDTH-1:0]  CDB_RoB_index,
  output logic [DATA_WIDTH-1:0] CDB_value,
  output logic                  CDB_src
);

  logic [RoB_WIDTH-1:0]  rs_head_idx, lsb_head_idx;
  logic [DATA_WIDTH-1:0] rs_head_val, lsb_head_val;
  logic [CNT_WIDTH-1:0]  rs_cnt, lsb_cnt;
  logic                  rs_nz, lsb_nz;
  logic                  rs_byp, lsb_byp;
  logic                  rs_cand, lsb_cand;
  logic                  rs_push, lsb_push;
  logic                  rs_pop, lsb_pop;
  logic [RoB_WIDTH-1:0]  rs_sel_idx, lsb_sel_idx;
  logic [DATA_WIDTH-1:0] rs_sel_val, lsb_sel_val;
  gnt_e                  gnt;

  logic                  en_q, en_d;
  logic [RoB_WIDTH-1:0]  idx_q, idx_d;
  logic [DATA_WIDTH-1:0] val_q, val_d;
  logic                  src_q, src_d;
  logic                  last_q, last_d;

  assign rs_nz  = (rs_cnt != '0);
  assign lsb_nz = (lsb_cnt != '0);

`ifdef CDB_BYPASS_EN
  // An empty queue is always ready, so its request may compete now.
  assign rs_byp  = ~rs_nz & RSCDB_en;
  assign lsb_byp = ~lsb_nz & LSBCDB_en;
`else
  assign rs_byp  = 1'b0;
  assign lsb_byp = 1'b0;
`endif

  assign rs_cand  = rs_nz | rs_byp;
  assign lsb_cand = lsb_nz | lsb_byp;

  always_comb begin
    gnt = GNT_NONE;
    unique case (1'b1)
      rs_cand & lsb_cand:
        gnt = (last_q == CDB_SRC_LSB) ? GNT_RS : GNT_LSB;
      rs_cand & ~lsb_cand:
        gnt = GNT_RS;
      ~rs_cand & lsb_cand:
        gnt = GNT_LSB;
      default:
        gnt = GNT_NONE;
    endcase
  end

  // A bypass winner goes straight to the bus and is not queued.
  assign rs_push  = RSCDB_en & ~(rs_byp & (gnt == GNT_RS));
  assign lsb_push = LSBCDB_en & ~(lsb_byp & (gnt == GNT_LSB));
  assign rs_pop   = (gnt == GNT_RS) & rs_nz;
  assign lsb_pop  = (gnt == GNT_LSB) & lsb_nz;

  assign rs_sel_idx  = rs_nz ? rs_head_idx : RSCDB_RoB_index;
  assign rs_sel_val  = rs_nz ? rs_head_val : RSCDB_value;
  assign lsb_sel_idx = lsb_nz ? lsb_head_idx : LSBCDB_RoB_index;
  assign lsb_sel_val = lsb_nz ? lsb_head_val : LSBCDB_value;

  cdb_queue #(
    .IW    (RoB_WIDTH),
    .DW    (DATA_WIDTH),
    .DEPTH (QUEUE_DEPTH),
    .CW    (CNT_WIDTH)
  ) u_rs_q (
    .clk_i      (Sys_clk),
    .rst_ni     (Sys_rst_n),
    .en_i       (Sys_rdy),
    .flush_i    (RoB_flush),
    .push_i     (rs_push),
    .idx_i      (RSCDB_RoB_index),
    .val_i      (RSCDB_value),
    .pop_i      (rs_pop),
    .head_idx_o (rs_head_idx),
    .head_val_o (rs_head_val),
    .count_o    (rs_cnt),
    .ready_o    (CDBRS_ready)
  );

  cdb_queue #(
    .IW    (RoB_WIDTH),
    .DW    (DATA_WIDTH),
    .DEPTH (QUEUE_DEPTH),
    .CW    (CNT_WIDTH)
  ) u_lsb_q (
    .clk_i      (Sys_clk),
    .rst_ni     (Sys_rst_n),
    .en_i       (Sys_rdy),
    .flush_i    (RoB_flush),
    .push_i     (lsb_push),
    .idx_i      (LSBCDB_RoB_index),
    .val_i      (LSBCDB_value),
    .pop_i      (lsb_pop),
    .head_idx_o (lsb_head_idx),
    .head_val_o (lsb_head_val),
    .count_o    (lsb_cnt),
    .ready_o    (CDBLSB_ready)
  );

  // Flush clears the bus valid but keeps last grant for fairness.
  always_comb begin
    en_d   = en_q;
    idx_d  = idx_q;
    val_d  = val_q;
    src_d  = src_q;
    last_d = last_q;
    if (RoB_flush) begin
      en_d = 1'b0;
    end else if (Sys_rdy) begin
      en_d = (gnt != GNT_NONE);
      if (gnt == GNT_RS) begin
        idx_d  = rs_sel_idx;
        val_d  = rs_sel_val;
        src_d  = CDB_SRC_RS;
        last_d = CDB_SRC_RS;
      end
      if (gnt == GNT_LSB) begin
        idx_d  = lsb_sel_idx;
        val_d  = lsb_sel_val;
        src_d  = CDB_SRC_LSB;
        last_d = CDB_SRC_LSB;
      end
    end
  end

  always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
    if (!Sys_rst_n) begin
      en_q   <= 1'b0;
      idx_q  <= '0;
      val_q  <= '0;
      src_q  <= CDB_SRC_RS;
      last_q <= CDB_SRC_LSB;
    end else begin
      en_q   <= en_d;
      idx_q  <= idx_d;
      val_q  <= val_d;
      src_q  <= src_d;
      last_q <= last_d;
    end
  end

  assign CDB_en        = en_q;
  assign CDB_RoB_index = idx_q;
  assign CDB_value     = val_q;
  assign CDB_src       = src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: vector table, corner sequences and random traffic
// against a queue-based reference of the CDB arbiter.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int IW = 4;
  localparam int DW = 32;
  localparam int D  = 2;
  localparam int CW = 2;
`ifdef CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rdy = 1'b0;
  logic          flush = 1'b0;
  logic          rs_en = 1'b0;
  logic [IW-1:0] rs_idx = '0;
  logic [DW-1:0] rs_val = '0;
  logic          lsb_en = 1'b0;
  logic [IW-1:0] lsb_idx = '0;
  logic [DW-1:0] lsb_val = '0;
  logic          rs_rdy, lsb_rdy;
  logic          cdb_en, cdb_src;
  logic [IW-1:0] cdb_idx;
  logic [DW-1:0] cdb_val;

  always #5 clk = ~clk;

  cdb_arbiter #(
    .RoB_WIDTH   (IW),
    .DATA_WIDTH  (DW),
    .QUEUE_DEPTH (D),
    .CNT_WIDTH   (CW)
  ) dut (
    .Sys_clk          (clk),
    .Sys_rst_n        (rst_n),
    .Sys_rdy          (rdy),
    .RoB_flush        (flush),
    .RSCDB_en         (rs_en),
    .RSCDB_RoB_index  (rs_idx),
    .RSCDB_value      (rs_val),
    .CDBRS_ready      (rs_rdy),
    .LSBCDB_en        (lsb_en),
    .LSBCDB_RoB_index (lsb_idx),
    .LSBCDB_value     (lsb_val),
    .CDBLSB_ready     (lsb_rdy),
    .CDB_en           (cdb_en),
    .CDB_RoB_index    (cdb_idx),
    .CDB_value        (cdb_val),
    .CDB_src          (cdb_src)
  );

  int checks = 0;
  int passes = 0;
  int cyc_n = 0;
  int viol = 0;

  typedef struct {
    logic [IW-1:0] idx;
    logic [DW-1:0] val;
  } ent_t;

  typedef struct {
    int            cyc;
    logic [IW-1:0] idx;
    logic          src;
  } bc_t;

  ent_t mq_rs[$];
  ent_t mq_lsb[$];
  bc_t  log_q[$];

  logic          m_en, m_src, m_last;
  logic [IW-1:0] m_idx;
  logic [DW-1:0] m_val;

  typedef struct {
    bit            r, f, re;
    logic [IW-1:0] ri;
    logic [DW-1:0] rv;
    bit            le;
    logic [IW-1:0] li;
    logic [DW-1:0] lv;
    bit            e_en;
    logic [IW-1:0] e_idx;
    logic [DW-1:0] e_val;
    bit            e_src, e_rr, e_lr;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic model_reset();
    mq_rs.delete();
    mq_lsb.delete();
    m_en = 1'b0;
    m_idx = '0;
    m_val = '0;
    m_src = 1'b0;
    m_last = CDB_SRC_LSB;
  endtask

  // Reference: arbitration rules applied to plain queues.
  task automatic model_step(input bit r, input bit f,
                            input bit re, input logic [IW-1:0] ri,
                            input logic [DW-1:0] rv,
                            input bit le, input logic [IW-1:0] li,
                            input logic [DW-1:0] lv);
    bit rok, lok, rc, lc;
    int g;
    ent_t e;
    if (f) begin
      mq_rs.delete();
      mq_lsb.delete();
      m_en = 1'b0;
    end else if (r) begin
      rok = re && (mq_rs.size() < D);
      lok = le && (mq_lsb.size() < D);
      rc = (mq_rs.size() > 0) || (BYP && rok);
      lc = (mq_lsb.size() > 0) || (BYP && lok);
      g = -1;
      if (rc && lc) g = (m_last == CDB_SRC_LSB) ? 0 : 1;
      else if (rc) g = 0;
      else if (lc) g = 1;
      m_en = (g >= 0);
      if (g == 0) begin
        if (mq_rs.size() > 0) e = mq_rs.pop_front();
        else begin
          e = '{ri, rv};
          rok = 1'b0;
        end
        m_idx = e.idx; m_val = e.val;
        m_src = 1'b0; m_last = 1'b0;
      end else if (g == 1) begin
        if (mq_lsb.size() > 0) e = mq_lsb.pop_front();
        else begin
          e = '{li, lv};
          lok = 1'b0;
        end
        m_idx = e.idx; m_val = e.val;
        m_src = 1'b1; m_last = 1'b1;
      end
      if (rok) mq_rs.push_back('{ri, rv});
      if (lok) mq_lsb.push_back('{li, lv});
    end
  endtask

  // One clock: drive, check ready, advance model, compare bus.
  task automatic cyc(input bit r, input bit f,
                     input bit re, input logic [IW-1:0] ri,
                     input logic [DW-1:0] rv,
                     input bit le, input logic [IW-1:0] li,
                     input logic [DW-1:0] lv);
    rdy = r; flush = f;
    rs_en = re; rs_idx = ri; rs_val = rv;
    lsb_en = le; lsb_idx = li; lsb_val = lv;
    check("rs_ready", 64'(rs_rdy), 64'(mq_rs.size() < D));
    check("lsb_ready", 64'(lsb_rdy), 64'(mq_lsb.size() < D));
    model_step(r, f, re, ri, rv, le, li, lv);
    @(posedge clk);
    #1;
    cyc_n++;
    if (cdb_en && r && !f) log_q.push_back('{cyc_n, cdb_idx, cdb_src});
    check("cdb_bus", {cdb_en, cdb_idx, cdb_val, cdb_src},
          {m_en, m_idx, m_val, m_src});
  endtask

  task automatic idle(input bit r);
    cyc(r, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
`ifdef CDB_BYPASS_EN
    tbl[0] = '{1,0,1,4'd1,32'hA1,1,4'd2,32'hB2, 1,4'd1,32'hA1,0,1,1};
    tbl[1] = '{1,0,1,4'd4,32'hC4,1,4'd5,32'hD5, 1,4'd2,32'hB2,1,1,1};
    tbl[2] = '{1,0,0,4'd0,32'h0,0,4'd0,32'h0,   1,4'd4,32'hC4,0,1,1};
    tbl[3] = '{1,0,0,4'd0,32'h0,0,4'd0,32'h0,   1,4'd5,32'hD5,1,1,1};
    tbl[4] = '{1,0,0,4'd0,32'h0,0,4'd0,32'h0,   0,4'd5,32'hD5,1,1,1};
    tbl[5] = '{1,0,1,4'd3,32'h11,0,4'd0,32'h0,  1,4'd3,32'h11,0,1,1};
    tbl[6] = '{1,0,0,4'd0,32'h0,0,4'd0,32'h0,   0,4'd3,32'h11,0,1,1};
    tbl[7] = '{1,0,0,4'd0,32'h0,0,4'd0,32'h0,   0,4'd3,32'h11,0,1,1};
    tbl[8] = '{1,0,0,4'd0,32'h0,0,4'd0,32'h0,   0,4'd3,32'h11,0,1,1};
`else
    tbl[0] = '{1,0,1,4'd1,32'hA1,1,4'd2,32'hB2, 0,4'd0,32'h0,0,1,1};
    tbl[1] = '{1,0,1,4'd4,32'hC4,1,4'd5,32'hD5, 1,4'd1,32'hA1,0,1,0};
    tbl[2] = '{1,0,0,4'd0,32'h0,0,4'd0,32'h0,   1,4'd2,32'hB2,1,1,1};
    tbl[3] = '{1,0,0,4'd0,32'h0,0,4'd0,32'h0,   1,4'd4,32'hC4,0,1,1};
    tbl[4] = '{1,0,0,4'd0,32'h0,0,4'd0,32'h0,   1,4'd5,32'hD5,1,1,1};
    tbl[5] = '{1,0,0,4'd0,32'h0,0,4'd0,32'h0,   0,4'd5,32'hD5,1,1,1};
    tbl[6] = '{1,0,1,4'd3,32'h11,0,4'd0,32'h0,  0,4'd5,32'hD5,1,1,1};
    tbl[7] = '{1,0,0,4'd0,32'h0,0,4'd0,32'h0,   1,4'd3,32'h11,0,1,1};
    tbl[8] = '{1,0,0,4'd0,32'h0,0,4'd0,32'h0,   0,4'd3,32'h11,0,1,1};
`endif

    // Reset state.
    #12;
    check("reset_state",
          {cdb_en, cdb_idx, cdb_val, cdb_src, rs_rdy, lsb_rdy},
          {1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 1'b1});
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;

    // Vector table.
    for (int i = 0; i < 9; i++) begin
      rdy = tbl[i].r; flush = tbl[i].f;
      rs_en = tbl[i].re; rs_idx = tbl[i].ri; rs_val = tbl[i].rv;
      lsb_en = tbl[i].le; lsb_idx = tbl[i].li; lsb_val = tbl[i].lv;
      model_step(tbl[i].r, tbl[i].f, tbl[i].re, tbl[i].ri, tbl[i].rv,
                 tbl[i].le, tbl[i].li, tbl[i].lv);
      @(posedge clk);
      #1;
      cyc_n++;
      check($sformatf("vec%0d", i),
            {cdb_en, cdb_idx, cdb_val, cdb_src, rs_rdy, lsb_rdy},
            {tbl[i].e_en, tbl[i].e_idx, tbl[i].e_val, tbl[i].e_src,
             tbl[i].e_rr, tbl[i].e_lr});
    end

    // Back-to-back RS results drain in order with no gap.
    log_q.delete();
    cyc(1, 0, 1, 4'd4, 32'h44, 0, '0, '0);
    cyc(1, 0, 1, 4'd5, 32'h55, 0, '0, '0);
    cyc(1, 0, 1, 4'd6, 32'h66, 0, '0, '0);
    idle(1); idle(1); idle(1);
    check("order_count", 64'(log_q.size()), 64'd3);
    for (int i = 0; i < log_q.size() && i < 3; i++) begin
      check($sformatf("order_idx%0d", i), 64'(log_q[i].idx), 64'(4 + i));
      check($sformatf("order_gap%0d", i), 64'(log_q[i].cyc),
            64'(log_q[0].cyc + i));
    end

    // Sys_rdy low freezes a live broadcast and blocks enqueue.
    cyc(1, 0, 1, 4'd7, 32'h77, 0, '0, '0);
`ifndef CDB_BYPASS_EN
    idle(1);
`endif
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 4'd9, 32'h99, 0, '0, '0);
      check($sformatf("freeze%0d", i), {cdb_en, cdb_idx, cdb_val},
            {1'b1, 4'd7, 32'h77});
    end
    idle(1);
    check("unfreeze_en", 64'(cdb_en), 64'd0);

    // Load queues, drive one over-full request, then flush.
    cyc(1, 0, 1, 4'd1, 32'h101, 1, 4'd2, 32'h202);
    cyc(1, 0, 1, 4'd3, 32'h303, 1, 4'd4, 32'h404);
`ifndef CDB_BYPASS_EN
    check("rs_full_ready", 64'(rs_rdy), 64'd0);
`endif
    cyc(1, 0, 1, 4'd5, 32'h505, 1, 4'd14, 32'hE0E);
    cyc(1, 1, 1, 4'd9, 32'h909, 0, '0, '0);
    check("flush_state", {cdb_en, rs_rdy, lsb_rdy}, {1'b1 ^ 1'b1, 2'b11});
    log_q.delete();
    for (int i = 0; i < 5; i++) idle(1);
    check("flush_no_bcast", 64'(log_q.size()), 64'd0);

    // Asynchronous reset between edges, mid-broadcast.
    cyc(1, 0, 1, 4'd10, 32'hAA, 0, '0, '0);
    cyc(1, 0, 1, 4'd11, 32'hBB, 0, '0, '0);
    check("pre_reset_en", 64'(cdb_en), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset",
          {cdb_en, cdb_idx, cdb_val, cdb_src, rs_rdy, lsb_rdy},
          {1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 1'b1});
    #1;
    rst_n = 1'b1;
    model_reset();
    idle(1);
    check("post_reset_empty", 64'(cdb_en), 64'd0);

    // Random traffic against the reference.
    for (int i = 0; i < 600; i++) begin
      bit r, f, re, le;
      r = ($urandom_range(0, 9) != 0);
      f = ($urandom_range(0, 31) == 0);
      re = $urandom_range(0, 1) == 1;
      le = $urandom_range(0, 1) == 1;
      if (re && mq_rs.size() >= D) begin
        if ($urandom_range(0, 3) != 0) re = 1'b0;
        else viol++;
      end
      if (le && mq_lsb.size() >= D) begin
        if ($urandom_range(0, 3) != 0) le = 1'b0;
        else viol++;
      end
      cyc(r, f, re, IW'($urandom), $urandom,
          le, IW'($urandom), $urandom);
    end
    idle(1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
